count_to_sync: RTL

Free-running VGA timing generator. It produces column/row counters and the horizontal/vertical sync pulses that match them, plus active-video, line-start and frame-start strobes. It is the source end of the sync interface that downstream counter-recovery logic consumes. It sits between the pixel-clock domain and the pattern/game renderers.

---
 rtl/count_to_sync.sv | 116 +++++++++++
 1 files changed

// File: rtl/count_to_sync.sv
`default_nettype none
// ============================================================================
// Module   : count_to_sync
// Desc     : Free-running VGA timing generator with column/row counters,
//            sync pulses, active-video flag and line/frame-start strobes.
// Revision : 1.0
// ============================================================================
module count_to_sync #(
   parameter int   TOTAL_COLS    = 1040,
   parameter int   TOTAL_ROWS    = 666,
   parameter int   ACTIVE_COLS   = 800,
   parameter int   ACTIVE_ROWS   = 600,
   parameter int   H_FRONT_PORCH = 56,
   parameter int   H_SYNC_WIDTH  = 120,
   parameter int   V_FRONT_PORCH = 37,
   parameter int   V_SYNC_WIDTH  = 6,
   parameter logic SYNC_POLARITY = 1'b1
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_En,
   output logic        o_HSync,
   output logic        o_VSync,
   output logic [11:0] o_Col_Count,
   output logic [11:0] o_Row_Count,
   output logic        o_Active,
   output logic        o_Line_Start,
   output logic        o_Frame_Start
);

   localparam logic [11:0] c_COL_LAST     = 12'(TOTAL_COLS - 1);
   localparam logic [11:0] c_ROW_LAST     = 12'(TOTAL_ROWS - 1);
   localparam logic [11:0] c_ACTIVE_COLS  = 12'(ACTIVE_COLS);
   localparam logic [11:0] c_ACTIVE_ROWS  = 12'(ACTIVE_ROWS);
   localparam logic [11:0] c_H_SYNC_START = 12'(ACTIVE_COLS + H_FRONT_PORCH);
   localparam logic [11:0] c_H_SYNC_END   = 12'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
   localparam logic [11:0] c_V_SYNC_START = 12'(ACTIVE_ROWS + V_FRONT_PORCH);
   localparam logic [11:0] c_V_SYNC_END   = 12'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

   generate
      if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_h_region_check
         $error("count_to_sync: horizontal sync region ends beyond TOTAL_COLS");
      end
      if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_v_region_check
         $error("count_to_sync: vertical sync region ends beyond TOTAL_ROWS");
      end
      if (TOTAL_COLS > 4096 || TOTAL_ROWS > 4096) begin : g_width_check
         $error("count_to_sync: totals do not fit 12-bit counters");
      end
   endgenerate

   logic [11:0] r_col;
   logic [11:0] r_row;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_active;
   logic        r_line_start;
   logic        r_frame_start;

   logic        w_col_wrap;
   logic        w_row_wrap;
   logic [11:0] w_col_next;
   logic [11:0] w_row_next;
   logic        w_hsync_on;
   logic        w_vsync_on;
   logic        w_active_next;

   // Derived outputs are decoded from the next counter values so that the
   // registered syncs and active flag always match the registered counters.
   always_comb begin
      w_col_wrap = (r_col == c_COL_LAST);
      w_row_wrap = (r_row == c_ROW_LAST);
      w_col_next = w_col_wrap ? 12'd0 : r_col + 12'd1;
      w_row_next = r_row;
      if (w_col_wrap) begin
         w_row_next = w_row_wrap ? 12'd0 : r_row + 12'd1;
      end
      w_hsync_on    = (w_col_next >= c_H_SYNC_START) && (w_col_next < c_H_SYNC_END);
      w_vsync_on    = (w_row_next >= c_V_SYNC_START) && (w_row_next < c_V_SYNC_END);
      w_active_next = (w_col_next < c_ACTIVE_COLS) && (w_row_next < c_ACTIVE_ROWS);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_col         <= 12'd0;
         r_row         <= 12'd0;
         r_hsync       <= ~SYNC_POLARITY;
         r_vsync       <= ~SYNC_POLARITY;
         r_active      <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (i_En) begin
         r_col         <= w_col_next;
         r_row         <= w_row_next;
         r_hsync       <= w_hsync_on ? SYNC_POLARITY : ~SYNC_POLARITY;
         r_vsync       <= w_vsync_on ? SYNC_POLARITY : ~SYNC_POLARITY;
         r_active      <= w_active_next;
         r_line_start  <= w_col_wrap;
         r_frame_start <= w_col_wrap && w_row_wrap;
      end else begin
         // Holding: position-derived outputs freeze, strobes must not repeat.
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end
   end

   assign o_Col_Count   = r_col;
   assign o_Row_Count   = r_row;
   assign o_HSync       = r_hsync;
   assign o_VSync       = r_vsync;
   assign o_Active      = r_active;
   assign o_Line_Start  = r_line_start;
   assign o_Frame_Start = r_frame_start;

endmodule
`default_nettype wire
